// File: rtl/wb_merge_stage.sv
// Writeback merge stage: pipeline writes own the register-file port; multdiv results wait in a FIFO.
// Optional feature macro: WB_BYPASS_EN (md result skips an empty FIFO straight to the write port).
module wb_merge_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 4,
  parameter int RSTATUS = 30,
  parameter int RLINK   = 31
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             pipe_insn,
  input  logic [DATA_W-1:0]       pipe_o,
  input  logic [DATA_W-1:0]       pipe_d,
  input  logic                    pipe_exception,
  input  logic                    md_valid,
  input  logic [REG_AW-1:0]       md_rd,
  input  logic [DATA_W-1:0]       md_result,
  input  logic                    md_exception,
  output logic                    md_ready,
  input  logic [REG_AW-1:0]       query_addr,
  output logic                    query_hit,
  output logic [$clog2(DEPTH):0]  pend_count,
  output logic [DATA_W-1:0]       data_writeReg,
  output logic [REG_AW-1:0]       ctrl_writeReg,
  output logic                    ctrl_writeEnable
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [REG_AW-1:0] ADDR_STATUS = REG_AW'(RSTATUS);
  localparam logic [REG_AW-1:0] ADDR_LINK   = REG_AW'(RLINK);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DEPTH);

  // ---------------- pipeline decode ----------------
  logic [4:0]        pipe_op;
  logic [REG_AW-1:0] pipe_rd;
  logic              pipe_dec_wr;
  logic [REG_AW-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_wr;
  logic [21:0]       unused_insn_bits;

  assign pipe_op          = pipe_insn[31:27];
  assign pipe_rd          = REG_AW'(pipe_insn[26:22]);
  assign unused_insn_bits = pipe_insn[21:0];

  always_comb begin
    pipe_dec_wr = 1'b0;
    case (pipe_op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_SETX: pipe_dec_wr = 1'b1;
      default:                                  pipe_dec_wr = 1'b0;
    endcase
  end

  always_comb begin
    pipe_addr = pipe_rd;
    if (pipe_op == OP_JAL) begin
      pipe_addr = ADDR_LINK;
    end else if (pipe_op == OP_SETX || pipe_exception) begin
      pipe_addr = ADDR_STATUS;
    end
  end

  assign pipe_data = (pipe_op == OP_LW) ? pipe_d : pipe_o;
  // $r0 is hard-wired, so a write aimed at it never reaches the port
  assign pipe_wr   = pipe_dec_wr && (pipe_addr != '0);

  // ---------------- multdiv FIFO ----------------
  logic [REG_AW-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  valid_next;
  logic [DEPTH-1:0]  slot_hit;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;

  logic [REG_AW-1:0] md_addr;
  logic              fifo_empty;
  logic              md_accept;
  logic              md_bypass;
  logic              enq;
  logic              deq;

  assign fifo_empty = (count_reg == '0);
  assign md_ready   = (count_reg < CNT_FULL);
  assign pend_count = count_reg;
  assign md_addr    = md_exception ? ADDR_STATUS : md_rd;
  // Beats with a zero destination are consumed but never stored
  assign md_accept  = md_valid && md_ready && (md_addr != '0);

`ifdef WB_BYPASS_EN
  assign md_bypass = md_accept && fifo_empty && !pipe_wr;
`else
  assign md_bypass = 1'b0;
`endif

  assign enq = md_accept && !md_bypass;
  assign deq = !pipe_wr && !fifo_empty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic slot_set;
      logic slot_clr;
      assign slot_set       = enq && (wr_ptr_reg == PTR_W'(gi));
      assign slot_clr       = deq && (rd_ptr_reg == PTR_W'(gi));
      assign valid_next[gi] = slot_set || (valid_reg[gi] && !slot_clr);
      // The head being drained this cycle still reports as pending
      assign slot_hit[gi]   = valid_reg[gi] && (addr_mem[gi] == query_addr);
    end
  endgenerate

  assign query_hit = (query_addr != '0) && (|slot_hit);

  always_comb begin
    count_next = count_reg;
    if (enq && !deq) begin
      count_next = count_reg + CNT_W'(1);
    end else if (deq && !enq) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= md_addr;
      data_mem[wr_ptr_reg] <= md_result;
    end
  end

  // ---------------- write-port register ----------------
  logic              we_reg;
  logic              we_next;
  logic [REG_AW-1:0] wreg_reg;
  logic [REG_AW-1:0] wreg_next;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] wdata_next;

  always_comb begin
    we_next    = 1'b0;
    wreg_next  = wreg_reg;
    wdata_next = wdata_reg;
    if (pipe_wr) begin
      we_next    = 1'b1;
      wreg_next  = pipe_addr;
      wdata_next = pipe_data;
    end else if (deq) begin
      we_next    = 1'b1;
      wreg_next  = addr_mem[rd_ptr_reg];
      wdata_next = data_mem[rd_ptr_reg];
    end else if (md_bypass) begin
      we_next    = 1'b1;
      wreg_next  = md_addr;
      wdata_next = md_result;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      we_reg     <= 1'b0;
      wreg_reg   <= '0;
      wdata_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
    end else begin
      we_reg     <= we_next;
      wreg_reg   <= wreg_next;
      wdata_reg  <= wdata_next;
      count_reg  <= count_next;
      valid_reg  <= valid_next;
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  assign ctrl_writeEnable = we_reg;
  assign ctrl_writeReg    = wreg_reg;
  assign data_writeReg    = wdata_reg;

endmodule

// File: tb/tb_wb_merge_stage.sv
// Bench for wb_merge_stage: decode vector table, then multi-cycle FIFO/bypass/reset sequences,
// with a queue model of pending multdiv results feeding a write-port scoreboard.
module tb_wb_merge_stage;
  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int DEPTH   = 4;
  localparam int RSTATUS = 30;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b00111;

  logic              clock = 1'b0;
  logic              reset;
  logic [31:0]       pipe_insn;
  logic [DATA_W-1:0] pipe_o;
  logic [DATA_W-1:0] pipe_d;
  logic              pipe_exception;
  logic              md_valid;
  logic [REG_AW-1:0] md_rd;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_ready;
  logic [REG_AW-1:0] query_addr;
  logic              query_hit;
  logic [2:0]        pend_count;
  logic [DATA_W-1:0] data_writeReg;
  logic [REG_AW-1:0] ctrl_writeReg;
  logic              ctrl_writeEnable;

  always #5 clock = ~clock;

  wb_merge_stage #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .RSTATUS(RSTATUS), .RLINK(31)
  ) dut (
    .clock(clock), .reset(reset),
    .pipe_insn(pipe_insn), .pipe_o(pipe_o), .pipe_d(pipe_d), .pipe_exception(pipe_exception),
    .md_valid(md_valid), .md_rd(md_rd), .md_result(md_result), .md_exception(md_exception),
    .md_ready(md_ready), .query_addr(query_addr), .query_hit(query_hit), .pend_count(pend_count),
    .data_writeReg(data_writeReg), .ctrl_writeReg(ctrl_writeReg), .ctrl_writeEnable(ctrl_writeEnable)
  );

  typedef struct {
    logic [31:0] insn;
    logic [31:0] o;
    logic [31:0] d;
    logic        pexc;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        mexc;
    logic [4:0]  q;
    logic        ep;   // expected pipeline write
    logic [4:0]  er;
    logic [31:0] ed;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rg;
    logic [31:0] dt;
  } wr_t;

  wr_t  sb[$];
  wr_t  md_q[$];
  vec_t tbl [12];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t pv(input logic [4:0] op, input logic [4:0] rd,
                              input logic [31:0] o, input logic [31:0] d, input logic exc,
                              input logic ep, input logic [4:0] er, input logic [31:0] ed);
    vec_t v;
    v.insn = {op, rd, 22'h0};
    v.o = o; v.d = d; v.pexc = exc;
    v.mv = 1'b0; v.mrd = '0; v.mres = '0; v.mexc = 1'b0; v.q = '0;
    v.ep = ep; v.er = er; v.ed = ed;
    return v;
  endfunction

  function automatic vec_t idle();
    return pv(OP_NOP, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
  endfunction

  function automatic vec_t pw(input logic [4:0] rd, input logic [31:0] o);
    return pv(OP_ADDI, rd, o, 32'h0, 1'b0, 1'b1, rd, o);
  endfunction

  function automatic vec_t md(input vec_t v, input logic [4:0] rd, input logic [31:0] res,
                              input logic exc);
    vec_t r;
    r = v; r.mv = 1'b1; r.mrd = rd; r.mres = res; r.mexc = exc;
    return r;
  endfunction

  function automatic vec_t qs(input vec_t v, input logic [4:0] q);
    vec_t r;
    r = v; r.q = q;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    pipe_insn = v.insn; pipe_o = v.o; pipe_d = v.d; pipe_exception = v.pexc;
    md_valid = v.mv; md_rd = v.mrd; md_result = v.mres; md_exception = v.mexc;
    query_addr = v.q;
  endtask

  // One clock cycle: drive, check status against the model, push the expected write, compare it.
  task automatic apply(input vec_t v);
    wr_t        e;
    wr_t        m;
    logic       exp_ready;
    logic       exp_hit;
    logic       accept;
    logic [4:0] maddr;
    drive(v);
    #2;
    exp_ready = (md_q.size() < DEPTH);
    exp_hit = 1'b0;
    foreach (md_q[k]) if (v.q != 5'd0 && md_q[k].rg == v.q) exp_hit = 1'b1;
    chk("md_ready", md_ready, exp_ready);
    chk("pend_count", pend_count, md_q.size());
    chk("query_hit", query_hit, exp_hit);

    maddr  = v.mexc ? 5'(RSTATUS) : v.mrd;
    accept = v.mv && exp_ready && (maddr != 5'd0);
    if (v.mv && !exp_ready)
      $display("note: md_valid while md_ready low at t=%0t, beat dropped", $time);

    e.we = 1'b0; e.rg = '0; e.dt = '0;
    if (v.ep) begin
      e.we = 1'b1; e.rg = v.er; e.dt = v.ed;
    end else if (md_q.size() > 0) begin
      e = md_q.pop_front();
      e.we = 1'b1;
    end
`ifdef WB_BYPASS_EN
    else if (accept) begin
      e.we = 1'b1; e.rg = maddr; e.dt = v.mres;
      accept = 1'b0;
    end
`endif
    sb.push_back(e);
    if (accept) begin
      m.we = 1'b1; m.rg = maddr; m.dt = v.mres;
      md_q.push_back(m);
    end

    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: got empty queue, want one entry");
    end else begin
      e = sb.pop_front();
      if (e.we) chk("wr_port", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, e.rg, e.dt});
      else      chk("wr_idle", ctrl_writeEnable, 1'b0);
    end
  endtask

  task automatic do_reset();
    drive(qs(idle(), 5'd9));
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_we", ctrl_writeEnable, 1'b0);
    chk("rst_reg", ctrl_writeReg, 5'd0);
    chk("rst_data", data_writeReg, 32'h0);
    chk("rst_pend", pend_count, 3'd0);
    chk("rst_ready", md_ready, 1'b1);
    chk("rst_hit", query_hit, 1'b0);
    reset = 1'b0;
    sb.delete();
    md_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = pv(OP_ADDI, 5'd5,  32'h1234, 32'h0,    1'b0, 1'b1, 5'd5,  32'h1234);
    tbl[1]  = idle();
    tbl[2]  = pv(OP_LW,   5'd7,  32'hBEEF, 32'hDEAD, 1'b0, 1'b1, 5'd7,  32'hDEAD);
    tbl[3]  = pv(OP_JAL,  5'd3,  32'h100,  32'h0,    1'b0, 1'b1, 5'd31, 32'h100);
    tbl[4]  = pv(OP_SETX, 5'd0,  32'h2A,   32'h0,    1'b0, 1'b1, 5'd30, 32'h2A);
    tbl[5]  = pv(OP_ADDI, 5'd6,  32'h9,    32'h0,    1'b1, 1'b1, 5'd30, 32'h9);
    tbl[6]  = pv(OP_ADDI, 5'd0,  32'h11,   32'h0,    1'b0, 1'b0, 5'd0,  32'h0);
    tbl[7]  = pv(OP_R,    5'd12, 32'hABC,  32'h0,    1'b0, 1'b1, 5'd12, 32'hABC);
    tbl[8]  = pv(OP_NOP,  5'd4,  32'h44,   32'h0,    1'b0, 1'b0, 5'd0,  32'h0);
    tbl[9]  = pv(OP_LW,   5'd0,  32'h5,    32'h6,    1'b0, 1'b0, 5'd0,  32'h0);
    tbl[10] = pv(OP_JAL,  5'd0,  32'h77,   32'h0,    1'b1, 1'b1, 5'd31, 32'h77);
    tbl[11] = pv(5'b10110, 5'd8, 32'h88,   32'h0,    1'b0, 1'b0, 5'd0,  32'h0);

    reset = 1'b1;
    drive(idle());
    @(posedge clock);
    do_reset();

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // md result held back by three pipeline writes
    apply(qs(md(pw(5'd1, 32'h101), 5'd9, 32'h55, 1'b0), 5'd9));
    chk("a_pend1", pend_count, 3'd1);
    apply(qs(pw(5'd2, 32'h102), 5'd9));
    apply(qs(pw(5'd3, 32'h103), 5'd9));
    apply(qs(idle(), 5'd9));
    chk("a_wr9", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd9, 32'h55});
    chk("a_pend0", pend_count, 3'd0);
    apply(idle());

    // fill to DEPTH under pipeline pressure, one beat while full, then drain in order
    for (int i = 0; i < DEPTH; i++)
      apply(md(pw(5'(10 + i), 32'h200 + i), 5'(16 + i), 32'hA0 + i, 1'b0));
    chk("b_full_ready", md_ready, 1'b0);
    chk("b_full_pend", pend_count, 3'd4);
    apply(md(pw(5'd14, 32'h204), 5'd20, 32'hEE, 1'b0));
    for (int i = 0; i < DEPTH; i++) begin
      apply(idle());
      chk("b_drain", {ctrl_writeEnable, ctrl_writeReg, data_writeReg},
          {1'b1, 5'(16 + i), 32'hA0 + i});
    end
    chk("b_empty", pend_count, 3'd0);

    // second fill across the wrap point, with a simultaneous enqueue/dequeue
    for (int i = 0; i < 3; i++)
      apply(md(pw(5'(1 + i), 32'h300 + i), 5'(24 + i), 32'hB0 + i, 1'b0));
    apply(md(idle(), 5'd27, 32'hB3, 1'b0));
    chk("b2_pend_same", pend_count, 3'd3);
    chk("b2_head", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd24, 32'hB0});
    for (int i = 0; i < 4; i++) apply(idle());

    // exception result redirected to RSTATUS
    apply(qs(md(pw(5'd2, 32'h400), 5'd12, 32'h3, 1'b1), 5'd30));
    apply(qs(pw(5'd3, 32'h401), 5'd12));
    apply(qs(pw(5'd4, 32'h402), 5'd0));
    apply(qs(pw(5'd5, 32'h403), 5'd30));
    chk("c_hit30", query_hit, 1'b1);
    apply(qs(idle(), 5'd30));
    chk("c_wr30", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd30, 32'h3});
    apply(idle());

    // bypass path (or two-cycle FIFO path when bypass is absent)
    apply(idle());
    apply(md(idle(), 5'd4, 32'h77, 1'b0));
`ifdef WB_BYPASS_EN
    chk("d_bypass_wr", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, {1'b1, 5'd4, 32'h77});
    chk("d_bypass_pend", pend_count, 3'd0);
`else
    chk("d_fifo_nowr", ctrl_writeEnable, 1'b0);
    chk("d_fifo_pend", pend_count, 3'd1);
`endif
    apply(idle());
    apply(idle());

    // zero destination is swallowed
    apply(md(pw(5'd6, 32'h500), 5'd0, 32'h99, 1'b0));
    chk("e_pend0", pend_count, 3'd0);
    apply(idle());

    // reset mid-drain discards pending entries
    for (int i = 0; i < 3; i++)
      apply(md(pw(5'(7 + i), 32'h600 + i), 5'(20 + i), 32'hC0 + i, 1'b0));
    chk("f_pend3", pend_count, 3'd3);
    do_reset();
    apply(idle());
    apply(idle());
    chk("f_nowr", ctrl_writeEnable, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
